// File: rtl/psum_quant_compressor.sv
// Requantizes a snapshot of the PE reducer's partial-sum buffer and streams the nonzero
// activations out as (value, index) beats. Optional build macro: PSUM_QUANT_RELU_EN clamps negatives to zero.
module psum_quant_compressor #(
  parameter int unsigned N_ENTRY = 32,
  parameter int unsigned IN_W    = 36,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SHIFT   = 8,
  parameter int unsigned IDX_W   = $clog2(N_ENTRY)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [IN_W-1:0]    i_buf [0:N_ENTRY-1],
  input  logic               i_ready,
  output logic               o_valid,
  output logic [OUT_W-1:0]   o_data,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done,
  output logic [IDX_W:0]     o_count
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic signed [IN_W-1:0] Q_MAX = IN_W'(signed'((2 ** (OUT_W - 1)) - 1));
  localparam logic signed [IN_W-1:0] Q_MIN = ~Q_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    TAIL  = 2'd3
  } state_t;

  // Arithmetic shift, then saturate to the output range.
  function automatic logic [OUT_W-1:0] quantize(input logic [IN_W-1:0] acc);
    logic signed [IN_W-1:0] sh;
    logic [OUT_W-1:0]       res;
    sh = $signed(acc) >>> SHIFT;
    if (sh > Q_MAX)      res = Q_MAX[OUT_W-1:0];
    else if (sh < Q_MIN) res = Q_MIN[OUT_W-1:0];
    else                 res = sh[OUT_W-1:0];
`ifdef PSUM_QUANT_RELU_EN
    if (sh < 0) res = '0;
`endif
    return res;
  endfunction

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [OUT_W-1:0]    snap_q [0:N_ENTRY-1];
  logic [OUT_W-1:0]    snap_d [0:N_ENTRY-1];
  logic [OUT_W-1:0]    q_c    [0:N_ENTRY-1];
  logic [N_ENTRY-1:0]  mask_q, mask_d, nz_c;
  logic                valid_q, valid_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                accept_c, advance_c, last_c;

  // Quantized view of the live buffer; only captured on an accepted start.
  always_comb begin
    for (int k = 0; k < int'(N_ENTRY); k++) begin
      q_c[k]  = quantize(i_buf[k]);
      nz_c[k] = |q_c[k];
    end
  end

  // Current entry is last when no mask bit above it is set.
  assign last_c   = ((mask_q >> ptr_q) >> 1) == '0;
  assign accept_c = valid_q & i_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    snap_d    = snap_q;
    mask_d    = mask_q;
    valid_d   = valid_q;
    data_d    = data_q;
    idx_d     = idx_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    count_d   = count_q;
    advance_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          snap_d  = q_c;
          mask_d  = nz_c;
          count_d = '0;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (accept_c) valid_d = 1'b0;
        if (!mask_q[ptr_q]) begin
          advance_c = 1'b1;
        end else if (!valid_q || accept_c) begin
          valid_d   = 1'b1;
          data_d    = snap_q[ptr_q];
          idx_d     = ptr_q;
          last_d    = last_c;
          count_d   = count_q + CNT_W'(1);
          advance_c = 1'b1;
        end
        if (advance_c) begin
          ptr_d = ptr_q + IDX_W'(1);
          if (ptr_q == IDX_W'(N_ENTRY - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // Non-empty frames retire through TAIL, one cycle after empty ones.
        if (!valid_q || accept_c) begin
          valid_d = 1'b0;
          if (count_q != '0) begin
            state_d = TAIL;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      TAIL: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mask_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      for (int k = 0; k < int'(N_ENTRY); k++) snap_q[k] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      count_q <= count_d;
      snap_q  <= snap_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_idx   = idx_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_count = count_q;

endmodule

// File: tb/tb_psum_quant_compressor.sv
// Self-checking bench for psum_quant_compressor: vector table of sparse frames plus
// hand-written backpressure, busy-restart and mid-frame reset sequences, all scoreboard checked.
module tb_psum_quant_compressor;

  localparam int unsigned N  = 32;
  localparam int unsigned IW = 36;
  localparam int unsigned OW = 16;
  localparam int unsigned XW = 5;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [IW-1:0] buf_v [0:N-1];
  logic          ready;
  logic          valid;
  logic [OW-1:0] data;
  logic [XW-1:0] idx;
  logic          last;
  logic          busy;
  logic          done;
  logic [XW:0]   count;

  psum_quant_compressor dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_buf   (buf_v),
    .i_ready (ready),
    .o_valid (valid),
    .o_data  (data),
    .o_idx   (idx),
    .o_last  (last),
    .o_busy  (busy),
    .o_done  (done),
    .o_count (count)
  );

  typedef struct {
    longint data;
    int     idx;
    bit     last;
  } beat_t;

  typedef struct {
    int          i0;
    logic [35:0] v0;
    int          i1;
    logic [35:0] v1;
    int          exp_cnt;
    longint      exp_d0;
    int          exp_done;
  } vec_t;

  beat_t  sb[$];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     beats, done_cnt, done_cyc, first_cyc, first_idx;
  longint first_data;
  bit     bp_mode = 1'b0;
  bit     bp_pat [4];
  bit     prev_stall = 1'b0;
  logic [OW-1:0] prev_data;
  logic [XW-1:0] prev_idx;
  logic          prev_last;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Floor-divide by 2^8, saturate to 16 bits, optional clamp of negatives.
  function automatic longint model_q(input logic [35:0] v);
    longint s, q;
    s = v[35] ? longint'(v) - (longint'(1) <<< 36) : longint'(v);
    if (s >= 0) q = s / 256;
    else        q = -((-s + 255) / 256);
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
`ifdef PSUM_QUANT_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic build_model();
    longint v;
    sb.delete();
    for (int k = 0; k < int'(N); k++) begin
      v = model_q(buf_v[k]);
      if (v != 0) sb.push_back('{data: v & 64'hFFFF, idx: k, last: 1'b0});
    end
    if (sb.size() > 0) sb[sb.size()-1].last = 1'b1;
    first_idx = (sb.size() > 0) ? sb[0].idx : -1;
  endtask

  task automatic scramble();
    for (int k = 0; k < int'(N); k++) buf_v[k] = 36'({$urandom(), $urandom()});
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream ready: always high, or the 1,0,0,1 backpressure pattern.
  initial begin
    int ph;
    ph = 0;
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) begin
        ready = bp_pat[ph];
        ph = (ph + 1) % 4;
      end else begin
        ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Output monitor: stall stability, scoreboard pops and done tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {valid, data, idx, last}, {1'b1, prev_data, prev_idx, prev_last});
      if (valid && ready) begin
        check("sb_nonempty", longint'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          beat_t e;
          e = sb.pop_front();
          check("beat_data", data, e.data);
          check("beat_idx", idx, e.idx);
          check("beat_last", last, e.last);
        end
        if (first_cyc < 0) begin
          first_cyc  = cyc;
          first_data = longint'(data);
        end
        beats++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("busy_at_done", busy, 0);
      end
      prev_stall = valid && !ready;
      prev_data  = data;
      prev_idx   = idx;
      prev_last  = last;
    end
  end

  task automatic run_frame(input int exp_cnt, input longint exp_d0, input int exp_done,
                           input int second_at, input bit check_lat);
    int t0;
    build_model();
    beats = 0; done_cnt = 0; done_cyc = -1; first_cyc = -1; first_data = -1;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    check("busy_after_start", busy, 1);
    for (int n = 0; n < 400 && done_cnt == 0; n++) begin
      @(posedge clk); #1;
      start = (second_at > 0 && cyc == t0 + second_at);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("done_pulses", done_cnt, 1);
    if (exp_done > 0) check("done_latency", done_cyc - t0, exp_done);
    check("beats", beats, exp_cnt);
    check("o_count", count, exp_cnt);
    check("sb_drained", sb.size(), 0);
    if (exp_cnt > 0) check("first_data", first_data, exp_d0);
    if (exp_cnt > 0 && check_lat) check("first_latency", first_cyc - t0, 2 + first_idx);
  endtask

  vec_t tbl [6];

  initial begin
    int t0;
    bp_pat[0] = 1'b1; bp_pat[1] = 1'b0; bp_pat[2] = 1'b0; bp_pat[3] = 1'b1;
    tbl[0] = '{3,  36'h500,         -1, 36'h0,     1, 5,     35};
    tbl[1] = '{10, 36'h7_FFFF_FFFF, 11, 36'h0FF,   1, 32767, 35};
`ifdef PSUM_QUANT_RELU_EN
    tbl[2] = '{0,  36'hF_FFFF_FE00, -1, 36'h0,     0, 0,     34};
    tbl[3] = '{5,  36'h8_0000_0000, -1, 36'h0,     0, 0,     34};
`else
    tbl[2] = '{0,  36'hF_FFFF_FE00, -1, 36'h0,     1, 16'hFFFE, 35};
    tbl[3] = '{5,  36'h8_0000_0000, -1, 36'h0,     1, 16'h8000, 35};
`endif
    tbl[4] = '{0,  36'h100,         31, 36'h1FF00, 2, 1,     35};
    tbl[5] = '{-1, 36'h0,           -1, 36'h0,     0, 0,     34};

    start = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < int'(N); k++) buf_v[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {valid, data, idx, last, busy, done, count}, 0);
    rst_n = 1'b1;

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < int'(N); k++) buf_v[k] = '0;
      if (tbl[r].i0 >= 0) buf_v[tbl[r].i0] = tbl[r].v0;
      if (tbl[r].i1 >= 0) buf_v[tbl[r].i1] = tbl[r].v1;
      run_frame(tbl[r].exp_cnt, tbl[r].exp_d0, tbl[r].exp_done, 0, 1'b1);
    end

    // Backpressure: ramp 1..32 with ready toggling 1,0,0,1.
    for (int k = 0; k < int'(N); k++) buf_v[k] = 36'((k + 1) << 8);
    bp_mode = 1'b1;
    run_frame(32, 1, -1, 0, 1'b0);
    bp_mode = 1'b0;

    // All-zero frame with a second start while busy.
    for (int k = 0; k < int'(N); k++) buf_v[k] = '0;
    run_frame(0, 0, 34, 5, 1'b0);

    // Reset during beat 4 of a full frame, then replay it.
    for (int k = 0; k < int'(N); k++) buf_v[k] = 36'((k + 1) << 8);
    build_model();
    beats = 0; done_cnt = 0; first_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 50 && cyc < t0 + 6; n++) begin
      @(posedge clk); #1;
    end
    check("pre_reset_beat", {valid, idx}, {1'b1, 5'd4});
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_count", count, 0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < int'(N); k++) buf_v[k] = 36'((k + 1) << 8);
    run_frame(32, 1, 35, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
